// File: rtl/screen_scanner.sv
// Frame scanner: snapshots the GameBox screen bus on request and streams the
// copy out one pixel per valid/ready beat in row-major order with line/frame markers.
module screen_scanner #(
    parameter  int SCR_W = 30,
    parameter  int SCR_H = 30,
    parameter  int PIX_W = 24,
    localparam int XW    = (SCR_W > 1) ? $clog2(SCR_W) : 1,
    localparam int YW    = (SCR_H > 1) ? $clog2(SCR_H) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [PIX_W*SCR_W*SCR_H-1:0] screen,
    input  logic                         frame_req,
    input  logic                         pix_ready,
    output logic                         pix_valid,
    output logic [PIX_W-1:0]             pix_data,
    output logic [XW-1:0]                pix_x,
    output logic [YW-1:0]                pix_y,
    output logic                         sof,
    output logic                         eol,
    output logic                         eof,
    output logic                         busy,
    output logic                         frame_done,
    output logic [7:0]                   drop_cnt
);

    // state  | meaning
    // IDLE   | waiting for frame_req; snapshot is taken on the accepting edge
    // STREAM | presenting shadow[idx] until all pixels have transferred
    // DONE   | single cycle after the last beat; frame_done pulses
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int NPIX = SCR_W * SCR_H;
    localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);
    localparam logic [XW-1:0] X_MAX    = XW'(SCR_W - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(SCR_H - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [7:0]      drop_q, drop_d;
    logic            load;

    logic [PIX_W-1:0] shadow_q [NPIX];
    logic [PIX_W-1:0] shadow_d [NPIX];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            drop_q  <= drop_d;
        end
    end

    // The shadow copy is deliberately left out of reset: its contents are
    // only ever read after a fresh load.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    always_comb begin
        for (int i = 0; i < NPIX; i++) begin
            shadow_d[i] = load ? screen[PIX_W*i +: PIX_W] : shadow_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        drop_d  = drop_q;
        load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_req) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (pix_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        x_d     = '0;
                        y_d     = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (x_q == X_MAX) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && frame_req && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_comb begin
        pix_valid  = (state_q == ST_STREAM);
        pix_data   = pix_valid ? shadow_q[idx_q] : '0;
        pix_x      = x_q;
        pix_y      = y_q;
        sof        = pix_valid && (x_q == '0) && (y_q == '0);
        eol        = pix_valid && (x_q == X_MAX);
        eof        = pix_valid && (x_q == X_MAX) && (y_q == Y_MAX);
        busy       = (state_q == ST_STREAM) || (state_q == ST_DONE);
        frame_done = (state_q == ST_DONE);
        drop_cnt   = drop_q;
    end

endmodule
